// File: rtl/rvfpm_result_rob_if.sv
// Handshake channels of the FPU result reorder buffer: allocate, writeback,
// commit/kill and the in-order result stream.
interface rvfpm_result_rob_if #(
  parameter int FLEN       = 32,
  parameter int X_ID_WIDTH = 4,
  parameter int FFLAGS_W   = 5
);
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [X_ID_WIDTH-1:0] alloc_id;
  logic [4:0]            alloc_rd;
  logic                  alloc_we;

  logic                  wb_valid;
  logic [X_ID_WIDTH-1:0] wb_id;
  logic [FLEN-1:0]       wb_data;
  logic [FFLAGS_W-1:0]   wb_fflags;

  logic                  commit_valid;
  logic [X_ID_WIDTH-1:0] commit_id;
  logic                  commit_kill;

  logic                  result_valid;
  logic                  result_ready;
  logic [X_ID_WIDTH-1:0] result_id;
  logic [FLEN-1:0]       result_data;
  logic [4:0]            result_rd;
  logic                  result_we;
  logic [FFLAGS_W-1:0]   result_fflags;

  modport master (
    output alloc_valid, alloc_id, alloc_rd, alloc_we,
    output wb_valid, wb_id, wb_data, wb_fflags,
    output commit_valid, commit_id, commit_kill,
    output result_ready,
    input  alloc_ready,
    input  result_valid, result_id, result_data, result_rd, result_we, result_fflags
  );

  modport slave (
    input  alloc_valid, alloc_id, alloc_rd, alloc_we,
    input  wb_valid, wb_id, wb_data, wb_fflags,
    input  commit_valid, commit_id, commit_kill,
    input  result_ready,
    output alloc_ready,
    output result_valid, result_id, result_data, result_rd, result_we, result_fflags
  );
endinterface

// File: rtl/rvfpm_result_rob.sv
// In-order result reorder buffer: allocates per offloaded instruction, captures
// out-of-order writebacks by ID, and retires committed results in issue order.
//
// head action | meaning
// H_IDLE      | head entry FREE, buffer empty
// H_STALL     | head waiting for writeback or commit
// H_EMIT      | head done and committed, offered on the result channel
// H_DROP      | head done and killed, freed silently this cycle
module rvfpm_result_rob #(
  parameter int DEPTH      = 8,
  parameter int FLEN       = 32,
  parameter int X_ID_WIDTH = 4,
  parameter int FFLAGS_W   = 5
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   flush,
  rvfpm_result_rob_if.slave      bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   proto_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {FREE, PEND, DONE} est_t;
  typedef enum logic [1:0] {H_IDLE, H_STALL, H_EMIT, H_DROP} hact_t;

  est_t                  e_state [DEPTH];
  logic [DEPTH-1:0]      e_com;
  logic [DEPTH-1:0]      e_kill;
  logic [DEPTH-1:0]      e_we;
  logic [X_ID_WIDTH-1:0] e_id    [DEPTH];
  logic [4:0]            e_rd    [DEPTH];
  logic [FLEN-1:0]       e_data  [DEPTH];
  logic [FFLAGS_W-1:0]   e_ff    [DEPTH];

  logic [PTR_W-1:0] head, tail;
  hact_t            hact;

  logic             alloc_fire, retire;
  logic             wb_hit, cm_hit, dup_hit;
  logic [PTR_W-1:0] wb_idx, cm_idx;
  logic             wb_new, cm_new;
  logic             wb_err, cm_err, dup_err;

  assign bus.alloc_ready = (count != CNT_W'(DEPTH));
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;

  // CAM lookups scan from head so the oldest matching entry wins.
  always_comb begin
    wb_hit  = 1'b0;
    wb_idx  = '0;
    cm_hit  = 1'b0;
    cm_idx  = '0;
    dup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!wb_hit && e_state[head + PTR_W'(i)] != FREE &&
          e_id[head + PTR_W'(i)] == bus.wb_id) begin
        wb_hit = 1'b1;
        wb_idx = head + PTR_W'(i);
      end
      if (!cm_hit && e_state[head + PTR_W'(i)] != FREE &&
          e_id[head + PTR_W'(i)] == bus.commit_id) begin
        cm_hit = 1'b1;
        cm_idx = head + PTR_W'(i);
      end
      if (e_state[head + PTR_W'(i)] != FREE && e_id[head + PTR_W'(i)] == bus.alloc_id)
        dup_hit = 1'b1;
    end
  end

  assign wb_new  = bus.wb_valid && alloc_fire && !wb_hit && (bus.wb_id == bus.alloc_id);
  assign cm_new  = bus.commit_valid && alloc_fire && !cm_hit && (bus.commit_id == bus.alloc_id);
  assign wb_err  = bus.wb_valid && (wb_hit ? (e_state[wb_idx] == DONE) : !wb_new);
  assign cm_err  = bus.commit_valid && !cm_hit && !cm_new;
  assign dup_err = alloc_fire && dup_hit;

  always_comb begin
    hact = H_IDLE;
    if (e_state[head] == DONE && e_com[head] && e_kill[head])
      hact = H_DROP;
    else if (e_state[head] == DONE && e_com[head])
      hact = H_EMIT;
    else if (e_state[head] != FREE)
      hact = H_STALL;
  end

  assign retire = (hact == H_DROP) || (hact == H_EMIT && bus.result_ready);

  always_comb begin
    bus.result_valid  = 1'b0;
    bus.result_id     = '0;
    bus.result_data   = '0;
    bus.result_rd     = '0;
    bus.result_we     = 1'b0;
    bus.result_fflags = '0;
    if (hact == H_EMIT) begin
      bus.result_valid  = 1'b1;
      bus.result_id     = e_id[head];
      bus.result_data   = e_data[head];
      bus.result_rd     = e_rd[head];
      bus.result_we     = e_we[head];
      bus.result_fflags = e_ff[head];
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      proto_err <= 1'b0;
      e_com     <= '0;
      e_kill    <= '0;
      e_we      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_state[i] <= FREE;
        e_id[i]    <= '0;
        e_rd[i]    <= '0;
        e_data[i]  <= '0;
        e_ff[i]    <= '0;
      end
    end else if (flush) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      e_com  <= '0;
      e_kill <= '0;
      for (int i = 0; i < DEPTH; i++) e_state[i] <= FREE;
    end else begin
      if (wb_err || cm_err || dup_err) proto_err <= 1'b1;
      if (retire) begin
        e_state[head] <= FREE;
        head          <= head + 1'b1;
      end
      if (bus.wb_valid && wb_hit && e_state[wb_idx] != DONE) begin
        e_state[wb_idx] <= DONE;
        e_data[wb_idx]  <= bus.wb_data;
        e_ff[wb_idx]    <= bus.wb_fflags;
      end
      if (bus.commit_valid && cm_hit) begin
        e_com[cm_idx]  <= 1'b1;
        e_kill[cm_idx] <= bus.commit_kill;
      end
      // The tail slot is FREE whenever alloc fires, so it never collides with the updates above.
      if (alloc_fire) begin
        e_state[tail] <= wb_new ? DONE : PEND;
        e_id[tail]    <= bus.alloc_id;
        e_rd[tail]    <= bus.alloc_rd;
        e_we[tail]    <= bus.alloc_we;
        e_com[tail]   <= cm_new;
        e_kill[tail]  <= cm_new && bus.commit_kill;
        if (wb_new) begin
          e_data[tail] <= bus.wb_data;
          e_ff[tail]   <= bus.wb_fflags;
        end
        tail <= tail + 1'b1;
      end
      count <= count + CNT_W'(alloc_fire) - CNT_W'(retire);
    end
  end
endmodule

// File: tb/tb_rvfpm_result_rob.sv
// Directed bench for rvfpm_result_rob: ordering, full/wrap, kill, backpressure,
// protocol errors, flush and asynchronous reset.
module tb_rvfpm_result_rob;
  logic       ck;
  logic       rst;
  logic       flush;
  logic [3:0] count;
  logic       proto_err;
  int         n_vec;
  int         n_err;

  rvfpm_result_rob_if #(.FLEN(32), .X_ID_WIDTH(4), .FFLAGS_W(5)) bus ();

  rvfpm_result_rob #(.DEPTH(8), .FLEN(32), .X_ID_WIDTH(4), .FFLAGS_W(5)) dut (
    .ck        (ck),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .count     (count),
    .proto_err (proto_err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid  = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.commit_valid = 1'b0;
    bus.commit_kill  = 1'b0;
    flush            = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.alloc_valid = 1'b0; bus.alloc_id = '0; bus.alloc_rd = '0; bus.alloc_we = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_id = '0; bus.wb_data = '0; bus.wb_fflags = '0;
    bus.commit_valid = 1'b0; bus.commit_id = '0; bus.commit_kill = 1'b0;
    bus.result_ready = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("rst_valid", bus.result_valid, 1'b0);
    chk("rst_ready", bus.alloc_ready, 1'b1);
    chk("rst_count", count, 4'd0);
    chk("rst_perr", proto_err, 1'b0);
    chk("rst_data", bus.result_data, 32'h0);
    @(negedge ck);
    rst = 1'b1;

    // In-order retire of out-of-order writebacks
    bus.alloc_valid = 1'b1;
    bus.alloc_id = 4'd1; tick();
    bus.alloc_id = 4'd2; tick();
    bus.alloc_id = 4'd3; tick();
    idle();
    chk("t1_count3", count, 4'd3);
    bus.wb_valid = 1'b1;
    bus.wb_id = 4'd3; bus.wb_data = 32'h40400000; tick();
    bus.wb_id = 4'd1; bus.wb_data = 32'h3F800000; tick();
    bus.wb_id = 4'd2; bus.wb_data = 32'h40000000; tick();
    idle();
    chk("t1_nocommit_valid", bus.result_valid, 1'b0);
    bus.result_ready = 1'b1;
    bus.commit_valid = 1'b1;
    bus.commit_id = 4'd1; tick();
    chk("t1_r1_valid", bus.result_valid, 1'b1);
    chk("t1_r1_id", bus.result_id, 4'd1);
    chk("t1_r1_data", bus.result_data, 32'h3F800000);
    bus.commit_id = 4'd2; tick();
    chk("t1_r2_id", bus.result_id, 4'd2);
    chk("t1_r2_data", bus.result_data, 32'h40000000);
    chk("t1_r2_count", count, 4'd2);
    bus.commit_id = 4'd3; tick();
    chk("t1_r3_id", bus.result_id, 4'd3);
    chk("t1_r3_data", bus.result_data, 32'h40400000);
    chk("t1_r3_count", count, 4'd1);
    idle(); tick();
    chk("t1_end_valid", bus.result_valid, 1'b0);
    chk("t1_end_count", count, 4'd0);
    chk("t1_perr", proto_err, 1'b0);

    // Fill, full backpressure, retire one, wrap-around allocate
    bus.result_ready = 1'b0;
    bus.alloc_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.alloc_id = 4'(i);
      tick();
    end
    idle();
    chk("t2_full_ready", bus.alloc_ready, 1'b0);
    chk("t2_full_count", count, 4'd8);
    bus.alloc_valid = 1'b1; bus.alloc_id = 4'd9; tick();
    idle();
    chk("t2_blocked_count", count, 4'd8);
    chk("t2_blocked_perr", proto_err, 1'b0);
    bus.wb_valid = 1'b1; bus.wb_id = 4'd0; bus.wb_data = 32'hA5A5A5A5;
    bus.commit_valid = 1'b1; bus.commit_id = 4'd0; tick();
    idle();
    chk("t2_id0_valid", bus.result_valid, 1'b1);
    chk("t2_id0_id", bus.result_id, 4'd0);
    chk("t2_id0_aready", bus.alloc_ready, 1'b0);
    bus.result_ready = 1'b1; tick();
    bus.result_ready = 1'b0;
    chk("t2_after_ret_aready", bus.alloc_ready, 1'b1);
    chk("t2_after_ret_count", count, 4'd7);
    chk("t2_after_ret_valid", bus.result_valid, 1'b0);
    bus.alloc_valid = 1'b1; bus.alloc_id = 4'd8; tick();
    idle();
    chk("t2_wrap_count", count, 4'd8);
    chk("t2_wrap_aready", bus.alloc_ready, 1'b0);
    flush = 1'b1; tick();
    idle();
    chk("t2_flush_count", count, 4'd0);
    chk("t2_flush_aready", bus.alloc_ready, 1'b1);

    // Killed head retires silently, next result follows
    bus.alloc_valid = 1'b1;
    bus.alloc_id = 4'd5; tick();
    bus.alloc_id = 4'd6; tick();
    idle();
    bus.wb_valid = 1'b1;
    bus.wb_id = 4'd5; bus.wb_data = 32'h11111111; tick();
    bus.wb_id = 4'd6; bus.wb_data = 32'h12345678; tick();
    idle();
    bus.result_ready = 1'b1;
    bus.commit_valid = 1'b1; bus.commit_id = 4'd5; bus.commit_kill = 1'b1; tick();
    chk("t3_kill_count", count, 4'd2);
    chk("t3_kill_valid", bus.result_valid, 1'b0);
    bus.commit_id = 4'd6; bus.commit_kill = 1'b0; tick();
    idle();
    chk("t3_r6_count", count, 4'd1);
    chk("t3_r6_valid", bus.result_valid, 1'b1);
    chk("t3_r6_id", bus.result_id, 4'd6);
    chk("t3_r6_data", bus.result_data, 32'h12345678);
    tick();
    chk("t3_end_count", count, 4'd0);
    chk("t3_end_valid", bus.result_valid, 1'b0);

    // Alloc + wb + commit in one cycle, then held under backpressure
    bus.result_ready = 1'b0;
    bus.alloc_valid = 1'b1; bus.alloc_id = 4'd4; bus.alloc_rd = 5'd10; bus.alloc_we = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_id = 4'd4; bus.wb_data = 32'hDEADBEEF; bus.wb_fflags = 5'h11;
    bus.commit_valid = 1'b1; bus.commit_id = 4'd4; tick();
    idle();
    chk("t4_valid", bus.result_valid, 1'b1);
    chk("t4_id", bus.result_id, 4'd4);
    chk("t4_rd", bus.result_rd, 5'd10);
    chk("t4_we", bus.result_we, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_hold_valid", bus.result_valid, 1'b1);
      chk("t4_hold_data", bus.result_data, 32'hDEADBEEF);
      chk("t4_hold_ff", bus.result_fflags, 5'h11);
    end
    bus.result_ready = 1'b1; tick();
    bus.result_ready = 1'b0;
    chk("t4_ret_valid", bus.result_valid, 1'b0);
    chk("t4_ret_count", count, 4'd0);
    chk("t4_perr", proto_err, 1'b0);

    // Stray writeback sets the sticky error
    bus.wb_valid = 1'b1; bus.wb_id = 4'd9; tick();
    idle();
    chk("t5_perr", proto_err, 1'b1);
    chk("t5_count", count, 4'd0);
    flush = 1'b1; tick();
    idle();
    chk("t5_perr_flush", proto_err, 1'b1);

    // Flush with pending entries, then async reset mid-stream
    bus.alloc_valid = 1'b1;
    bus.alloc_id = 4'd1; tick();
    bus.alloc_id = 4'd2; tick();
    bus.alloc_id = 4'd3; tick();
    idle();
    chk("t6_count3", count, 4'd3);
    flush = 1'b1; tick();
    idle();
    chk("t6_flush_count", count, 4'd0);
    chk("t6_flush_valid", bus.result_valid, 1'b0);
    bus.alloc_valid = 1'b1; bus.alloc_id = 4'd7;
    bus.wb_valid = 1'b1; bus.wb_id = 4'd7; bus.wb_data = 32'hCAFEF00D;
    bus.commit_valid = 1'b1; bus.commit_id = 4'd7; tick();
    idle();
    chk("t6_pre_valid", bus.result_valid, 1'b1);
    chk("t6_pre_data", bus.result_data, 32'hCAFEF00D);
    @(posedge ck);
    #3 rst = 1'b0;
    #1;
    chk("t6_rst_valid", bus.result_valid, 1'b0);
    chk("t6_rst_count", count, 4'd0);
    chk("t6_rst_perr", proto_err, 1'b0);
    chk("t6_rst_aready", bus.alloc_ready, 1'b1);
    chk("t6_rst_data", bus.result_data, 32'h0);
    @(negedge ck);
    rst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rvfpm_result_rob.md
Name: rvfpm_result_rob

Overview:
- Parametrised in-order result reorder buffer between the FPU execute stages and the CORE-V-XIF result interface.
- Allocates one entry per accepted offloaded instruction, captures out-of-order writebacks by ID, and tracks commit/kill per entry.
- Retires entries strictly in issue order: committed results go out on the valid/ready result channel, killed ones are dropped silently.
- Replaces the single-outstanding result path with DEPTH in-flight instructions.

Parameters:
DEPTH, 8, entries; power of two, >= 2
FLEN, 32, result data width
X_ID_WIDTH, 4, XIF instruction ID width
FFLAGS_W, 5, exception-flag width carried with each result

Ports:
ck  in  1  clock
rst  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all entries
alloc_valid  in  1  allocate entry (issue accepted)
alloc_ready  out  1  buffer not full
alloc_id  in  X_ID_WIDTH  instruction ID
alloc_rd  in  5  destination register
alloc_we  in  1  instruction writes a register
wb_valid  in  1  execute writeback strobe
wb_id  in  X_ID_WIDTH  writeback ID
wb_data  in  FLEN  result data
wb_fflags  in  FFLAGS_W  exception flags
commit_valid  in  1  commit strobe
commit_id  in  X_ID_WIDTH  committed ID
commit_kill  in  1  1 = kill that ID
result_valid  out  1  head result available
result_ready  in  1  consumer accepts
result_id  out  X_ID_WIDTH  head ID
result_data  out  FLEN  head data
result_rd  out  5  head rd
result_we  out  1  head we
result_fflags  out  FFLAGS_W  head flags
count  out  $clog2(DEPTH)+1  occupied entries
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst low, async): head = tail = 0, count = 0, all entries FREE, result_valid = 0, result_* = 0, proto_err = 0, alloc_ready = 1.
- Entry fields: state {FREE, PEND, DONE}, committed, killed, id, rd, we, data, fflags.
- Alloc: on alloc_valid && alloc_ready, entry[tail] <- PEND with id/rd/we; committed = killed = 0; tail wraps modulo DEPTH.
- alloc_ready = (count != DEPTH). It does not depend on same-cycle retire; no combinational path from result_ready.
- Writeback: wb_valid does a CAM match of wb_id against all non-FREE entries; match -> data/fflags captured, state DONE.
  - No match, or match on an entry already DONE: write ignored, proto_err set.
- Commit: commit_valid matches commit_id the same way; match -> committed = 1 and killed = commit_kill.
  - No match: ignored, proto_err set.
  - Alloc and commit in the same cycle with equal IDs: commit applies to the new entry.
  - Alloc and wb in the same cycle with equal IDs: wb applies to the new entry, which lands DONE.
  - wb and commit in the same cycle on one entry: both apply.
- IDs are unique among non-FREE entries. A duplicate alloc_id sets proto_err; the entry is still allocated, and CAM lookups take the oldest match.
- Head state machine:
  - Head FREE: nothing.
  - Head DONE && committed && !killed: result_valid = 1, result_* driven from the head entry (registered storage, no combinational path from inputs). Retire on result_ready: entry FREE, head++.
  - Head DONE && killed: retired silently in one cycle with result_valid = 0; consumes no handshake.
  - Head PEND, or not committed: stall. Younger DONE entries wait.
- Latency: result_valid rises the cycle after the later of (wb, commit) is sampled, given the entry is at head. Back-to-back ready entries retire one per cycle with result_ready held high.
- result_valid, once high, stays high and result_* stay stable until accepted. flush is the only exception.
- count: +1 on alloc, -1 on retire (either kind), unchanged when both happen in the same cycle. A same-cycle alloc with retire while full is blocked, since alloc_ready was 0.
- flush (sync, priority over all other inputs that cycle): all entries FREE, pointers/count 0, result_valid 0. proto_err is not cleared by flush.
- Reset mid-operation: immediate clear to reset values. In-flight results are lost.

Test Plan:
- Alloc IDs 1,2,3; wb 3,1,2 (data 0x3F800000, 0x40000000, 0x40400000); commit 1,2,3; ready=1 -> results in order ID1, ID2, ID3 with matching data, one per cycle, proto_err 0.
- Fill DEPTH=8 (IDs 0..7) -> alloc_ready 0, count 8. Retire ID0 -> alloc_ready 1 next cycle. Alloc ID 8 (wrap) -> it is accepted.
- Alloc 5,6; wb both; commit_kill on 5, commit 6 -> no result for 5 (silent retire), single result ID6 the cycle after; count goes 2 -> 1 -> 0.
- Head DONE and committed, result_ready held 0 for 4 cycles -> result_valid and result_data stable for all 4. Ready=1 -> retires, count decrements.
- wb_id=9 with no entry allocated -> ignored, proto_err=1 and sticky through a flush.
- Three entries pending, flush pulse -> count 0, result_valid 0. Asserting rst low mid-stream -> all outputs return to reset values asynchronously.
